// File: rtl/rr_incr_pkg.sv
// Shared types and defaults for the round-robin increment arbiter.
package rr_incr_pkg;
  localparam int DEF_W      = 8;
  localparam int DEF_STAT_W = 16;

  typedef logic src_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/rr_incr_arbiter_if.sv
// Handshake bundle: two requesters in, one tagged result out.
interface rr_incr_arbiter_if #(parameter int W = 8);
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_incr_stage.sv
// One valid/data/src register slice; load wins over clear, clear drops valid only.
module rr_incr_stage
  import rr_incr_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  input  src_t         src_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output src_t         src_o
);
  logic         vld_q;
  logic [W-1:0] data_q;
  src_t         src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= 1'b0;
    end else if (ld_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      src_q  <= src_i;
    end else if (clr_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign src_o  = src_q;
endmodule

// File: rtl/rr_incr_arbiter.sv
// Two requesters share one capture + increment pipeline under round-robin arbitration.
// Optional grant counters are built when RR_ARB_STATS_EN is defined.
module rr_incr_arbiter
  import rr_incr_pkg::*;
#(
  parameter int W = DEF_W
`ifdef RR_ARB_STATS_EN
  , parameter int STAT_W = DEF_STAT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_incr_arbiter_if.slave  bus
`ifdef RR_ARB_STATS_EN
  , output logic [STAT_W-1:0] gnt_cnt0
  , output logic [STAT_W-1:0] gnt_cnt1
`endif
);
  occ_e         occ_q;
  logic         last_gnt_q;
  src_t         grant;
  logic         accept_ok, accept, adv, drain;
  logic         s1_vld, out_vld;
  logic [W-1:0] s1_data, out_data;
  src_t         s1_src, out_src;

  assign adv   = !out_vld | bus.out_ready;
  assign drain = out_vld & bus.out_ready;
  // Only a full pipeline with a stalled output can refuse a new operand.
  assign accept_ok = (occ_q != OCC_FULL) | bus.out_ready;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_gnt_q;
    else                                  grant = bus.req1_valid;
  end

  assign accept = accept_ok & (grant ? bus.req1_valid : bus.req0_valid);

  // Gated by rst_n so nothing handshakes while the pipeline is held in reset.
  assign bus.req0_ready = rst_n & accept_ok & (grant == 1'b0);
  assign bus.req1_ready = rst_n & accept_ok & (grant == 1'b1);

  rr_incr_stage #(.W(W)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (accept),
    .clr_i  (s1_vld & adv),
    .data_i (grant ? bus.req1_data : bus.req0_data),
    .src_i  (grant),
    .vld_o  (s1_vld),
    .data_o (s1_data),
    .src_o  (s1_src)
  );

  rr_incr_stage #(.W(W)) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (s1_vld & adv),
    .clr_i  (drain),
    .data_i (s1_data + W'(1)),
    .src_i  (s1_src),
    .vld_o  (out_vld),
    .data_o (out_data),
    .src_o  (out_src)
  );

  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_data;
  assign bus.out_src   = out_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      last_gnt_q <= 1'b1;
    end else begin
      if (accept) last_gnt_q <= grant;
      case (occ_q)
        OCC_EMPTY: if (accept) occ_q <= OCC_ONE;
        OCC_ONE: begin
          if (accept && !drain)      occ_q <= OCC_FULL;
          else if (!accept && drain) occ_q <= OCC_EMPTY;
        end
        OCC_FULL:  if (drain && !accept) occ_q <= OCC_ONE;
        default:   occ_q <= OCC_EMPTY;
      endcase
    end
  end

`ifdef RR_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (grant == 1'b0 && !(&cnt0_q)) cnt0_q <= cnt0_q + STAT_W'(1);
      if (grant == 1'b1 && !(&cnt1_q)) cnt1_q <= cnt1_q + STAT_W'(1);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_rr_incr_arbiter.sv
// Randomized + directed bench for rr_incr_arbiter against a queue-based reference model.
module tb_rr_incr_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_incr_arbiter_if #(.W(W)) bus ();

`ifdef RR_ARB_STATS_EN
  logic [15:0] gc0, gc1;
  logic [1:0]  sc0, sc1;
  rr_incr_arbiter_if #(.W(W)) bus2 ();
  rr_incr_arbiter #(.W(W), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(gc0), .gnt_cnt1(gc1));
  rr_incr_arbiter #(.W(W), .STAT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .gnt_cnt0(sc0), .gnt_cnt1(sc1));
`else
  rr_incr_arbiter #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: in-flight results in accept order, each tagged with its capture cycle.
  typedef struct { logic src; logic [W-1:0] d; int cap; } item_t;
  item_t       q[$];
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic [15:0] m_c0 = '0, m_c1 = '0;
  logic        p_acc = 0, p_drain = 0, p_src = 0;
  logic [W-1:0] p_data = '0;

  logic ev, ok, g, er0, er1;

  always @(negedge clk) begin
    p_acc = 0; p_drain = 0;
    if (rst_n) begin
      // Head is at the output once a clock edge has passed since its capture.
      ev  = (q.size() > 0) && (q[0].cap < cyc);
      ok  = (q.size() < 2) || bus.out_ready;
      g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      er0 = ok && !g;
      er1 = ok && g;
      chk("req0_ready", bus.req0_ready, er0);
      chk("req1_ready", bus.req1_ready, er1);
      chk("out_valid",  bus.out_valid,  ev);
      if (ev) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_src",  bus.out_src,  q[0].src);
      end
`ifdef RR_ARB_STATS_EN
      chk("gnt_cnt0", gc0, m_c0);
      chk("gnt_cnt1", gc1, m_c1);
`endif
      p_src   = g;
      p_data  = g ? bus.req1_data : bus.req0_data;
      p_acc   = g ? (bus.req1_valid && er1) : (bus.req0_valid && er0);
      p_drain = ev && bus.out_ready;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_last = 1'b1;
      m_c0 = '0;
      m_c1 = '0;
    end else begin
      if (p_drain) void'(q.pop_front());
      if (p_acc) begin
        q.push_back('{p_src, p_data + 8'd1, cyc});
        m_last = p_src;
        if (!p_src && m_c0 != 16'hFFFF) m_c0++;
        if (p_src && m_c1 != 16'hFFFF) m_c1++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  logic       gr [4];
  logic [W-1:0] sd;

  initial begin
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_data = 8'h10; bus.req1_data = 8'h20; bus.out_ready = 1;
`ifdef RR_ARB_STATS_EN
    bus2.req0_valid = 0; bus2.req1_valid = 0;
    bus2.req0_data = 8'h00; bus2.req1_data = 8'h00; bus2.out_ready = 1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_out_src",   bus.out_src, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    @(posedge clk); #3; rst_n = 1;

    // Continuous contention: grants alternate starting at requester 0.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      gr[k] = bus.req1_ready;
      cycle();
      bus.req0_data = 8'h11 + 8'(k);
      bus.req1_data = 8'h21 + 8'(k);
    end
    chk("rr_grant_0", gr[0], 0);
    chk("rr_grant_1", gr[1], 1);
    chk("rr_grant_2", gr[2], 0);
    chk("rr_grant_3", gr[3], 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) cycle();

    // Wrap-around on requester 1.
    bus.req1_valid = 1; bus.req1_data = 8'hFF;
    cycle(); bus.req1_valid = 0;
    cycle();
    chk("wrap_valid", bus.out_valid, 1);
    chk("wrap_data",  bus.out_data, 8'h00);
    chk("wrap_src",   bus.out_src, 1);
    repeat (2) cycle();

    // Single requester 0, latency two edges.
    bus.req0_valid = 1; bus.req0_data = 8'h05;
    @(negedge clk);
    chk("solo_ready", bus.req0_ready, 1);
    cycle(); bus.req0_valid = 0;
    chk("solo_lat1_valid", bus.out_valid, 0);
    cycle();
    chk("solo_valid", bus.out_valid, 1);
    chk("solo_data",  bus.out_data, 8'h06);
    chk("solo_src",   bus.out_src, 0);
    repeat (2) cycle();

    // Backpressure with both requesters streaming.
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.req0_data = 8'h40 + 8'(k); bus.req1_data = 8'h80 + 8'(k);
      cycle();
    end
    bus.out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) sd = bus.out_data;
      if (k == 3) begin
        chk("bp_req0_ready", bus.req0_ready, 0);
        chk("bp_req1_ready", bus.req1_ready, 0);
        chk("bp_data_stable", bus.out_data, sd);
      end
      cycle();
      bus.req0_data = 8'h50 + 8'(k); bus.req1_data = 8'h90 + 8'(k);
    end
    bus.out_ready = 1;
    repeat (6) cycle();
    bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (3) cycle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.req0_valid = ($urandom_range(3) != 0);
      bus.req1_valid = ($urandom_range(3) != 0);
      bus.req0_data  = 8'($urandom);
      bus.req1_data  = 8'($urandom);
      bus.out_ready  = ($urandom_range(2) != 0);
      cycle();
    end

    // Reset with both stages full.
    bus.req0_valid = 1; bus.req1_valid = 1; bus.out_ready = 0;
    repeat (3) cycle();
    #1; rst_n = 0; #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_req0_ready", bus.req0_ready, 0);
    chk("midrst_req1_ready", bus.req1_ready, 0);
    @(posedge clk); #3;
    rst_n = 1; bus.out_ready = 1;
`ifdef RR_ARB_STATS_EN
    bus2.req0_valid = 1;
`endif
    @(negedge clk);
    chk("post_rst_req0_ready", bus.req0_ready, 1);
    chk("post_rst_req1_ready", bus.req1_ready, 0);
    for (int k = 0; k < 10; k++) begin
      cycle();
`ifdef RR_ARB_STATS_EN
      if (k == 4) bus2.req0_valid = 0;
`endif
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
`ifdef RR_ARB_STATS_EN
    chk("stats_cnt0", gc0, 16'd5);
    chk("stats_cnt1", gc1, 16'd5);
    chk("stats_sat",  sc0, 2'b11);
`endif
    repeat (4) cycle();
    chk("final_empty", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
